io_bridge: RTL and testbench

I/O responder on the far side of the nano processor controller's OUTPUT/INPUT instructions. Buffers words emitted by OUTPUT, on the controller's `LdOUTPUT` strobe, into a small FIFO drained by an external valid/ready consumer. Supplies INPUT data from a one-entry holding register filled by an external valid/ready producer. Back-pressures the controller through `stall` when it cannot complete a request.

---
 rtl/nano_pkg.sv | 9 +
 rtl/io_fifo.sv | 69 ++++++
 rtl/io_bridge.sv | 90 +++++++++
 tb/tb_io_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Shared nano processor constants: datapath width, I/O opcodes and bridge sizing.
package nano_pkg;

    localparam int DATA_W = 8;
    localparam logic [3:0] OP_INPUT  = 4'hE;
    localparam logic [3:0] OP_OUTPUT = 4'hF;
    localparam int OUT_DEPTH = 4;

endpackage

// File: rtl/io_fifo.sv
// Output FIFO for io_bridge: registered storage, wrapping pointers, occupancy count,
// push/pop arbitration (push at full is only taken together with a pop).
module io_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic              drop
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              full, push, pop;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign head_valid = (count_q != '0);
    assign pop        = head_valid & pop_ready;
    assign push       = push_req & (~full | pop);
    assign drop       = push_req & full & ~pop;
    assign head_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads 0 while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// I/O responder for the nano controller's OUTPUT/INPUT instructions.
// Optional sticky overflow flag enabled by defining IO_BRIDGE_OVF_EN.
module io_bridge
    import nano_pkg::*;
#(
    parameter int DATA_W    = nano_pkg::DATA_W,
    parameter int OUT_DEPTH = nano_pkg::OUT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_output,
    input  logic [DATA_W-1:0] out_data,
    input  logic              in_req,
    output logic [DATA_W-1:0] in_data,
    output logic              stall,
    output logic              ext_out_valid,
    output logic [DATA_W-1:0] ext_out_data,
    input  logic              ext_out_ready,
    input  logic              ext_in_valid,
    input  logic [DATA_W-1:0] ext_in_data,
    output logic              ext_in_ready,
    output logic              ovf
);

    logic              fifo_drop;
    logic              in_full_q, in_full_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              capture, consume;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_req   (ld_output),
        .push_data  (out_data),
        .pop_ready  (ext_out_ready),
        .head_data  (ext_out_data),
        .head_valid (ext_out_valid),
        .drop       (fifo_drop)
    );

    assign ext_in_ready = ~in_full_q;
    assign capture      = ext_in_valid & ~in_full_q;
    assign consume      = in_req & in_full_q;
    assign in_data      = in_data_q;

    // fifo_drop is exactly "push at full without a pop", the output half of the stall.
    assign stall = (in_req & ~in_full_q) | fifo_drop;

    always_comb begin
        in_full_d = in_full_q;
        in_data_d = in_data_q;
        if (capture) begin
            in_full_d = 1'b1;
            in_data_d = ext_in_data;
        end else if (consume) begin
            in_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_full_q <= 1'b0;
            in_data_q <= '0;
        end else begin
            in_full_q <= in_full_d;
            in_data_q <= in_data_d;
        end
    end

`ifdef IO_BRIDGE_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q | fifo_drop;
    assign ovf   = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: table-driven vectors plus hand-written
// sequences for reset, FIFO full/overflow, input stall and pointer wrap.
module tb_io_bridge;

    logic       clk;
    logic       rst;
    logic       ld_output;
    logic [7:0] out_data;
    logic       in_req;
    logic [7:0] in_data;
    logic       stall;
    logic       ext_out_valid;
    logic [7:0] ext_out_data;
    logic       ext_out_ready;
    logic       ext_in_valid;
    logic [7:0] ext_in_data;
    logic       ext_in_ready;
    logic       ovf;

`ifdef IO_BRIDGE_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    int total_checks  = 0;
    int passed_checks = 0;

    typedef struct {
        logic       ld;
        logic [7:0] od;
        logic       req;
        logic       ordy;
        logic       ivld;
        logic [7:0] idat;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_stall;
        logic       e_irdy;
        logic [7:0] e_indata;
        string      name;
    } vec_t;

    vec_t vecs [10];

    io_bridge #(
        .DATA_W    (8),
        .OUT_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_output     (ld_output),
        .out_data      (out_data),
        .in_req        (in_req),
        .in_data       (in_data),
        .stall         (stall),
        .ext_out_valid (ext_out_valid),
        .ext_out_data  (ext_out_data),
        .ext_out_ready (ext_out_ready),
        .ext_in_valid  (ext_in_valid),
        .ext_in_data   (ext_in_data),
        .ext_in_ready  (ext_in_ready),
        .ovf           (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge and let combinational outputs settle.
    task automatic applyStimulus(input logic ld, input logic [7:0] od, input logic req,
                                 input logic ordy, input logic ivld, input logic [7:0] idat);
        ld_output     = ld;
        out_data      = od;
        in_req        = req;
        ext_out_ready = ordy;
        ext_in_valid  = ivld;
        ext_in_data   = idat;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // valid/data stall in_rdy in_data: pre-edge values for that cycle's inputs
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, "push11"};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h00, "push22"};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h00, "push33"};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h00, "pop11"};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 8'h00, "pop22"};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 8'h00, "pop33"};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, "empty"};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, "preload3c"};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, "req_nostall"};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, "consumed"};

        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;

        checkOutput("reset_valid",    {7'd0, ext_out_valid}, 8'h00);
        checkOutput("reset_in_ready", {7'd0, ext_in_ready},  8'h01);
        checkOutput("reset_ovf",      {7'd0, ovf},           8'h00);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].od, vecs[i].req, vecs[i].ordy, vecs[i].ivld, vecs[i].idat);
            checkOutput({vecs[i].name, "_valid"}, {7'd0, ext_out_valid}, {7'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                checkOutput({vecs[i].name, "_data"}, ext_out_data, vecs[i].e_data);
            end
            checkOutput({vecs[i].name, "_stall"},    {7'd0, stall},        {7'd0, vecs[i].e_stall});
            checkOutput({vecs[i].name, "_in_ready"}, {7'd0, ext_in_ready}, {7'd0, vecs[i].e_irdy});
            checkOutput({vecs[i].name, "_in_data"},  in_data,              vecs[i].e_indata);
            checkOutput({vecs[i].name, "_ovf"},      {7'd0, ovf},          8'h00);
            tick();
        end

        // Mid-transfer reset with three words buffered and a word held for INPUT.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, (i == 0), 8'h77);
            tick();
        end
        idle();
        checkOutput("pre_reset_valid", {7'd0, ext_out_valid}, 8'h01);
        checkOutput("pre_reset_in_data", in_data, 8'h77);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        #1;
        checkOutput("rst_valid",    {7'd0, ext_out_valid}, 8'h00);
        checkOutput("rst_out_data", ext_out_data,          8'h00);
        checkOutput("rst_in_ready", {7'd0, ext_in_ready},  8'h01);
        checkOutput("rst_in_data",  in_data,               8'h00);
        checkOutput("rst_ovf",      {7'd0, ovf},           8'h00);
        checkOutput("rst_stall",    {7'd0, stall},         8'h01);
        tick();
        idle();
        rst = 1'b1;
        tick();

        // Fill four words; no stall means count restarted from 0.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h01 + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("fill%0d_stall", i), {7'd0, stall}, 8'h00);
            tick();
        end
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("full_drop_stall", {7'd0, stall}, 8'h01);
        tick();
        idle();
        checkOutput("full_drop_ovf", {7'd0, ovf}, {7'd0, OVF_EXP});
        checkOutput("full_drop_head", ext_out_data, 8'h01);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("full_pushpop_stall", {7'd0, stall}, 8'h00);
        tick();
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("still_full_stall", {7'd0, stall}, 8'h01);
        tick();
        begin
            logic [7:0] drain_exp [4];
            drain_exp = '{8'h02, 8'h03, 8'h04, 8'h55};
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
                checkOutput($sformatf("drain%0d_valid", i), {7'd0, ext_out_valid}, 8'h01);
                checkOutput($sformatf("drain%0d_data", i), ext_out_data, drain_exp[i]);
                tick();
            end
        end
        idle();
        checkOutput("drained_valid", {7'd0, ext_out_valid}, 8'h00);
        checkOutput("drained_ovf",   {7'd0, ovf},           {7'd0, OVF_EXP});

        // INPUT with empty holding register: stall until the producer delivers.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("in_wait%0d_stall", i), {7'd0, stall}, 8'h01);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5);
        checkOutput("in_capture_stall", {7'd0, stall}, 8'h01);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("in_ready_stall",   {7'd0, stall},        8'h00);
        checkOutput("in_ready_data",    in_data,              8'hA5);
        checkOutput("in_ready_full",    {7'd0, ext_in_ready}, 8'h00);
        tick();
        idle();
        checkOutput("in_consumed_ready", {7'd0, ext_in_ready}, 8'h01);
        tick();

        // Alternating push/pop across more than one pointer lap.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("wrap_push%0d_stall", i), {7'd0, stall}, 8'h00);
            tick();
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("wrap_pop%0d_valid", i), {7'd0, ext_out_valid}, 8'h01);
            checkOutput($sformatf("wrap_pop%0d_data", i), ext_out_data, 8'h80 + 8'(i));
            tick();
        end
        idle();
        checkOutput("wrap_end_valid", {7'd0, ext_out_valid}, 8'h00);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
